// File: rtl/seq_divider.sv
// seq_divider: iterative signed divider, 2W-bit dividend / W-bit divisor.
// Restoring shift/subtract on magnitudes, one quotient bit per clock, followed
// by a fix-up edge that applies signs, range-checks and saturates.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   start      request, accepted on a rising edge while busy=0
//   dividend   2W-bit signed dividend, sampled on the accepting edge
//   divisor    W-bit signed divisor, sampled on the accepting edge
//   busy       high while an operation is in progress (CALC and FIX)
//   done       one-cycle pulse, results valid from this cycle on
//   quotient   W-bit signed quotient, truncated toward zero
//   remainder  W-bit signed remainder, sign of the dividend
//   ovf        quotient did not fit in W-bit signed (saturated)
//   dbz        divisor was zero
module seq_divider #(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [2*W-1:0] dividend,
  input  logic [W-1:0]   divisor,
  output logic           busy,
  output logic           done,
  output logic [W-1:0]   quotient,
  output logic [W-1:0]   remainder,
  output logic           ovf,
  output logic           dbz
);

  localparam int CW = $clog2(2*W);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t         state_reg, state_next;
  logic [CW-1:0]  count_reg;
  logic [2*W-1:0] dq_reg;       // dividend magnitude shifts out, quotient bits shift in
  logic [W:0]     part_reg;     // partial remainder
  logic [W-1:0]   dsr_reg;      // divisor magnitude
  logic           dend_neg_reg;
  logic           dsr_neg_reg;
  logic           accept;
  logic           last_step;

  assign last_step = (count_reg == CW'(2*W-1));

  // ---------------- FSM ----------------
  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    busy       = 1'b0;
    done       = 1'b0;
    accept     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = CALC;
          accept     = 1'b1;
        end
      end
      CALC: begin
        busy = 1'b1;
        if (last_step) state_next = FIX;
      end
      FIX: begin
        busy       = 1'b1;
        state_next = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          state_next = CALC;
          accept     = 1'b1;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // ---------------- step logic ----------------
  logic [W:0]   part_sh;
  logic [W+1:0] trial;

  // Partial remainder stays below the divisor magnitude (<= 2^(W-1)), so after
  // the shift it fits in W+1 bits; one extra bit holds the trial's sign.
  assign part_sh = {part_reg[W-1:0], dq_reg[2*W-1]};
  assign trial   = {1'b0, part_sh} - {2'b00, dsr_reg};

  // ---------------- fix-up logic ----------------
  localparam logic [2*W-1:0] QPOS_MAX = (2*W)'((1 << (W-1)) - 1);
  localparam logic [2*W-1:0] QNEG_MAX = (2*W)'(1 << (W-1));

  logic         q_neg;
  logic         q_range_err;
  logic [W-1:0] q_signed;
  logic [W-1:0] r_signed;
  logic [W-1:0] q_sat;

  assign q_neg       = dend_neg_reg ^ dsr_neg_reg;
  // Negative results may reach -2^(W-1); positive ones only 2^(W-1)-1.
  assign q_range_err = q_neg ? (dq_reg > QNEG_MAX) : (dq_reg > QPOS_MAX);
  assign q_signed    = q_neg ? (W'(0) - dq_reg[W-1:0]) : dq_reg[W-1:0];
  assign r_signed    = dend_neg_reg ? (W'(0) - part_reg[W-1:0]) : part_reg[W-1:0];
  assign q_sat       = q_neg ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};

  // ---------------- datapath ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg    <= '0;
      dq_reg       <= '0;
      part_reg     <= '0;
      dsr_reg      <= '0;
      dend_neg_reg <= 1'b0;
      dsr_neg_reg  <= 1'b0;
      quotient     <= '0;
      remainder    <= '0;
      ovf          <= 1'b0;
      dbz          <= 1'b0;
    end else if (accept) begin
      // Magnitudes as unsigned: the most negative value maps to 2^(n-1).
      dend_neg_reg <= dividend[2*W-1];
      dsr_neg_reg  <= divisor[W-1];
      dq_reg       <= dividend[2*W-1] ? (2*W)'(0) - dividend : dividend;
      dsr_reg      <= divisor[W-1] ? W'(0) - divisor : divisor;
      part_reg     <= '0;
      count_reg    <= '0;
    end else if (state_reg == CALC) begin
      if (!trial[W+1]) begin
        part_reg <= trial[W:0];
        dq_reg   <= {dq_reg[2*W-2:0], 1'b1};
      end else begin
        part_reg <= part_sh;
        dq_reg   <= {dq_reg[2*W-2:0], 1'b0};
      end
      count_reg <= count_reg + CW'(1);
    end else if (state_reg == FIX) begin
      if (dsr_reg == '0) begin
        quotient  <= '0;
        remainder <= '0;
        ovf       <= 1'b0;
        dbz       <= 1'b1;
      end else if (q_range_err) begin
        quotient  <= q_sat;
        remainder <= '0;
        ovf       <= 1'b1;
        dbz       <= 1'b0;
      end else begin
        quotient  <= q_signed;
        remainder <= r_signed;
        ovf       <= 1'b0;
        dbz       <= 1'b0;
      end
    end
  end

endmodule
